bloom_filter_engine: RTL
========================

Name: bloom_filter_engine

Overview:
Stateful, parametrised successor to the combinational Bloom-filter match logic in the NIDS datapath. Holds the M-bit Bloom array internally and runs INSERT (program a signature), QUERY (test a packet key) and CLEAR operations. Uses NUM_HASH configurable hash indices and a 2-stage valid/ready pipeline with backpressure, plus a saturating insert counter. Sits between the packet key extractor (upstream) and the alert/decision logic (downstream).

Parameters:
KEY_W, 56, key width in bits
M, 64, Bloom array size in bits; power of 2, 8..1024; LOG2M = clog2(M)
NUM_HASH, 3, number of hash indices per key, 1..8
ROT, 7, per-hash rotation step in bits, 1..KEY_W-1
CNT_W, 16, insert counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_op  in  2  0=QUERY, 1=INSERT, 2=CLEAR, 3=reserved (treated as QUERY)
in_key  in  KEY_W  key; ignored for CLEAR
out_valid  out  1  response valid
out_ready  in  1  downstream accepts response
out_hit  out  1  QUERY: all indexed bits set; INSERT: all indexed bits set before insert; CLEAR: 0
out_op  out  2  op of this response (reserved code reported as 0)
bloom_bits  out  M  current array contents, debug/snapshot
insert_cnt  out  CNT_W  INSERTs committed since reset/CLEAR, saturating

Behaviour:
- Hash: for k in 0..NUM_HASH-1: r_k = in_key rotated left by (k*ROT) mod KEY_W; zero-extend at MSB to a multiple of LOG2M; idx_k = XOR of all LOG2M-bit chunks (chunk 0 = bits LOG2M-1:0). Duplicate indices are legal.
- Stage A reg (a_valid, op, key) loads on accept. Stage B reg (b_valid, hit, op) is the response.
- a_adv = a_valid & (!b_valid | out_ready); in_ready = !a_valid | a_adv (combinational, no in_valid dependency).
- On a_adv edge, the op commits to the array and its result loads into stage B. hit = AND of array[idx_k] read before this edge's write.
  - INSERT: array[idx_k] <= 1 for all k; insert_cnt += 1, saturating at all-ones.
  - CLEAR: array <= 0; insert_cnt <= 0; hit = 0.
  - QUERY: no state change.
- If a_valid=0 and b_valid=1 with out_ready=1: b_valid <= 0.
- Latency: accepted at edge N -> committed and out_valid=1 after edge N+1. Throughput 1 op/cycle when out_ready=1.
- Ops commit strictly in accept order; a QUERY right after an INSERT of the same key returns hit=1.
- Backpressure: out_valid=1 & out_ready=0 holds out_hit/out_op stable, stage A holds, in_ready=0 if a_valid. No loss, no duplication.
- Reset (any time, incl. mid-operation): a_valid=0, b_valid=0, out_valid=0, out_hit=0, out_op=0, bloom_bits=0, insert_cnt=0. In-flight ops are discarded and never commit.
- bloom_bits and insert_cnt are registered and reflect state after the most recent commit.

Test Plan:
- Reset, then QUERY key 0x00000000000001 -> out_hit=0 two edges after accept; bloom_bits=0.
- INSERT key 0x00000000000001 (defaults) -> idx {1,2,4}; bloom_bits=0x16; out_hit=0; insert_cnt=1. Repeat INSERT -> out_hit=1; insert_cnt=2.
- Back-to-back INSERT key 0x1 then QUERY key 0x1, in_valid held, out_ready=1 -> responses on consecutive cycles: (INSERT, hit=0), (QUERY, hit=1).
- out_ready=0 for 5 cycles while issuing 3 ops -> in_ready drops after 2 accepted; out_hit/out_op stable; release -> 3 responses in order, none lost.
- CLEAR after several INSERTs -> bloom_bits=0, insert_cnt=0, out_op=2, out_hit=0; then QUERY key 0x1 -> hit=0.
- Assert rst_n low asynchronously with both stages full -> outputs immediately 0, array 0; no response is emitted after release.

Source files
------------

// File: rtl/bloom_filter_engine_if.sv
// Request/response handshake bundle for bloom_filter_engine.
//   in_valid/in_ready/in_op/in_key     : upstream request channel
//   out_valid/out_ready/out_hit/out_op : downstream response channel
// slave  : the engine side
// master : the requester/consumer side
interface bloom_filter_engine_if #(
  parameter int unsigned KEY_W = 56
) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [KEY_W-1:0] in_key;
  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic [1:0]       out_op;

  modport slave (
    input  in_valid, in_op, in_key, out_ready,
    output in_ready, out_valid, out_hit, out_op
  );

  modport master (
    output in_valid, in_op, in_key, out_ready,
    input  in_ready, out_valid, out_hit, out_op
  );
endinterface

// File: rtl/bloom_filter_engine.sv
// Stateful Bloom filter: holds an M-bit array and executes QUERY, INSERT and
// CLEAR requests through a two-stage valid/ready pipeline.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   bus         : request/response handshake (slave modport)
//   bloom_bits  : registered array contents after the latest commit
//   insert_cnt  : INSERTs committed since reset/CLEAR, saturating
// Stage A holds the accepted request; the op commits to the array as it
// moves into stage B, which holds the response presented downstream.
module bloom_filter_engine #(
  parameter int unsigned KEY_W    = 56,
  parameter int unsigned M        = 64,
  parameter int unsigned NUM_HASH = 3,
  parameter int unsigned ROT      = 7,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bloom_filter_engine_if.slave bus,
  output logic [M-1:0]         bloom_bits,
  output logic [CNT_W-1:0]     insert_cnt
);

  localparam int unsigned LOG2M  = $clog2(M);
  localparam int unsigned NCHUNK = (KEY_W + LOG2M - 1) / LOG2M;
  localparam int unsigned PADW   = NCHUNK * LOG2M;

  typedef enum logic [1:0] {
    OP_QUERY  = 2'd0,
    OP_INSERT = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  // Rotate left by (k*ROT) mod KEY_W, zero-pad to whole chunks, fold by XOR.
  // Rotation is taken from the doubled key so a zero shift needs no special case.
  function automatic logic [LOG2M-1:0] hash_idx(input logic [KEY_W-1:0] key,
                                                input int unsigned      k);
    logic [2*KEY_W-1:0] dbl;
    logic [PADW-1:0]    padded;
    logic [LOG2M-1:0]   idx;
    int unsigned        sh;
    sh     = (k * ROT) % KEY_W;
    dbl    = {key, key} >> (KEY_W - sh);
    padded = '0;
    padded[KEY_W-1:0] = dbl[KEY_W-1:0];
    idx    = '0;
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      idx = idx ^ padded[c*LOG2M +: LOG2M];
    end
    return idx;
  endfunction

  logic             a_valid;
  op_e              a_op;
  logic [KEY_W-1:0] a_key;
  logic             b_valid;
  logic             b_hit;
  op_e              b_op;

  logic             a_adv;
  logic             accept;
  logic             hit;
  logic [M-1:0]     set_mask;
  op_e              in_op_n;

  assign a_adv        = a_valid & (~b_valid | bus.out_ready);
  assign bus.in_ready = ~a_valid | a_adv;
  assign accept       = bus.in_valid & bus.in_ready;
  assign in_op_n      = (op_e'(bus.in_op) == OP_RSVD) ? OP_QUERY : op_e'(bus.in_op);

  assign bus.out_valid = b_valid;
  assign bus.out_hit   = b_hit;
  assign bus.out_op    = b_op;

  // hit reads the array before this edge's write, so an INSERT reports
  // whether the key was already present.
  always_comb begin
    hit      = 1'b1;
    set_mask = '0;
    for (int unsigned k = 0; k < NUM_HASH; k++) begin
      hit = hit & bloom_bits[hash_idx(a_key, k)];
      set_mask[hash_idx(a_key, k)] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_op    <= OP_QUERY;
      a_key   <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_op    <= in_op_n;
      a_key   <= bus.in_key;
    end else if (a_adv) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid    <= 1'b0;
      b_hit      <= 1'b0;
      b_op       <= OP_QUERY;
      bloom_bits <= '0;
      insert_cnt <= '0;
    end else if (a_adv) begin
      b_valid <= 1'b1;
      b_op    <= a_op;
      b_hit   <= (a_op == OP_CLEAR) ? 1'b0 : hit;
      case (a_op)
        OP_INSERT: begin
          bloom_bits <= bloom_bits | set_mask;
          if (insert_cnt != '1) insert_cnt <= insert_cnt + 1'b1;
        end
        OP_CLEAR: begin
          bloom_bits <= '0;
          insert_cnt <= '0;
        end
        default: ;
      endcase
    end else if (bus.out_ready) begin
      b_valid <= 1'b0;
    end
  end

endmodule
